// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one I2C_Controller write engine with timeout.
// Define I2C_ARB_RETRY_EN to relaunch NACKed commands up to MAX_RETRY extra times.
module i2c_cmd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [24*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  output logic                   busy,
  output logic                   i2c_go,
  output logic [23:0]            i2c_data,
  input  logic                   i2c_end,
  input  logic                   i2c_ack
);
  localparam int LW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_END, WAIT_CLR, RESP} state_t;
  state_t state, nxt;
  logic [1:0] end_q, ack_q;
  logic end_s, ack_s;
  logic [LW-1:0] last_grant, grant;
  logic [TW-1:0] timer;
  logic any, tmo_hit, tmo_flag, nack, relaunch;
  assign end_s = end_q[1];
  assign ack_s = ack_q[1];
  assign tmo_hit = timer == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      end_q <= '0;
      ack_q <= '0;
    end else begin
      end_q <= {end_q[0], i2c_end};
      ack_q <= {ack_q[0], i2c_ack};
    end
  // first pending requester strictly after the last grant, wrapping
  always_comb begin
    grant = last_grant;
    any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      if (!any && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        grant = LW'((int'(last_grant) + k) % NUM_REQ);
        any = 1'b1;
      end
  end
  assign req_ready = (state == IDLE && any && !reset) ? NUM_REQ'(1) << grant : '0;
`ifdef I2C_ARB_RETRY_EN
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) retry_cnt <= '0;
    else if (state == IDLE) retry_cnt <= '0;
    else if (state == RESP && relaunch) retry_cnt <= retry_cnt + 1'b1;
  assign relaunch = !tmo_flag && nack && retry_cnt < RW'(MAX_RETRY);
`else
  assign relaunch = 1'b0;
`endif
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = any ? LAUNCH : IDLE;
      LAUNCH:   nxt = WAIT_END;
      WAIT_END: nxt = (end_s || tmo_hit) ? WAIT_CLR : WAIT_END;
      WAIT_CLR: nxt = (!end_s || tmo_hit) ? RESP : WAIT_CLR;
      RESP:     nxt = relaunch ? LAUNCH : IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      i2c_go <= 1'b0;
      i2c_data <= '0;
      busy <= 1'b0;
      req_done <= '0;
      req_err <= '0;
      last_grant <= LW'(NUM_REQ - 1);
      timer <= '0;
      tmo_flag <= 1'b0;
      nack <= 1'b0;
    end else begin
      req_done <= '0;
      req_err <= '0;
      case (state)
        IDLE: if (any) begin
          i2c_data <= req_data[24*grant +: 24];
          last_grant <= grant;
          busy <= 1'b1;
          tmo_flag <= 1'b0;
          nack <= 1'b0;
        end
        LAUNCH: begin
          i2c_go <= 1'b1;
          timer <= '0;
        end
        // END wins over a simultaneous timer expiry
        WAIT_END: begin
          timer <= (end_s || tmo_hit) ? '0 : timer + 1'b1;
          if (end_s) nack <= ack_s;
          if (end_s || tmo_hit) i2c_go <= 1'b0;
          if (!end_s && tmo_hit) tmo_flag <= 1'b1;
        end
        WAIT_CLR: begin
          timer <= timer + 1'b1;
          if (end_s && tmo_hit) tmo_flag <= 1'b1;
        end
        RESP: if (!relaunch) begin
          busy <= 1'b0;
          if (tmo_flag || nack) req_err[last_grant] <= 1'b1;
          else req_done[last_grant] <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: table-driven, directed and random checks of i2c_cmd_arbiter against a
// queue-based requester/controller model; works with or without I2C_ARB_RETRY_EN.
module tb_i2c_cmd_arbiter;
  localparam int NR = 3;
  localparam int MR = 3;
  localparam int TMO = 100;
`ifdef I2C_ARB_RETRY_EN
  localparam int NACK_GO = MR + 1, N2_GO = 3, N2_ERR = 0;
`else
  localparam int NACK_GO = 1, N2_GO = 1, N2_ERR = 1;
`endif
  typedef struct packed {
    logic [23:0] data;
    logic [7:0]  nacks;
    logic [7:0]  hold;
    logic        hang;
  } cmd_t;
  typedef struct {
    logic [NR-1:0] mask;
    int nacks;
    int hold;
    bit hang;
    int exp_first;
    int exp_done;
    int exp_err;
  } vec_t;
  logic clk, reset;
  logic [NR-1:0] req_valid, req_ready, req_done, req_err;
  logic [24*NR-1:0] req_data;
  logic busy, i2c_go, i2c_end, i2c_ack;
  logic [23:0] i2c_data;
  i2c_cmd_arbiter #(.NUM_REQ(NR), .MAX_RETRY(MR), .TIMEOUT_CYC(TMO)) dut (
    .CLOCK_50(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err), .busy(busy),
    .i2c_go(i2c_go), .i2c_data(i2c_data), .i2c_end(i2c_end), .i2c_ack(i2c_ack)
  );
  int checks = 0, failures = 0, cyc = 0;
  cmd_t ring [NR][16];
  int head [NR], tail [NR];
  bit popq [NR];
  cmd_t cur;
  int cur_idx, model_last, go_edges, go_len, since_acc, end_low, attempt, ctl_d;
  int n_done, n_err, n_go, exp_go;
  bit in_flight, exp_err, exp_tmo, go_prev, ctl_busy, c_prev;
  logic [23:0] go_data_seen;
  int grant_log [$];
  vec_t tbl [7];
  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction
  task automatic enq(int r, logic [23:0] d, int n, int h, bit hg);
    ring[r][tail[r]] = '{data: d, nacks: 8'(n), hold: 8'(h), hang: hg};
    tail[r] = (tail[r] + 1) % 16;
  endtask
  function automatic bit queues_empty();
    for (int i = 0; i < NR; i++) if (head[i] != tail[i]) return 0;
    return 1;
  endfunction
  task automatic wait_idle();
    int n = 0;
    while (n < 3000 && !(queues_empty() && !in_flight && !ctl_busy && !busy && end_low > 5 && req_valid == '0)) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", n < 3000, 1);
  endtask
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycles %0d exceeded limit", cyc);
      $fatal(1, "watchdog");
    end
  end
  // requester driver: each requester presents the head of its queue until accepted
  initial begin
    req_valid = '0;
    req_data = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (popq[i]) begin
          head[i] = (head[i] + 1) % 16;
          popq[i] = 0;
        end
        req_valid[i] = head[i] != tail[i];
        req_data[24*i +: 24] = ring[i][head[i]].data;
      end
    end
  end
  // controller model: END after a random delay, held for the command's hold time
  initial begin
    i2c_end = 0;
    i2c_ack = 0;
    ctl_busy = 0;
    c_prev = 0;
    forever begin
      @(negedge clk);
      if (i2c_go && !c_prev && !reset) begin
        ctl_busy = 1;
        attempt++;
        if (cur.hang) begin
          while (i2c_go) @(negedge clk);
        end else begin
          ctl_d = $urandom_range(1, 6);
          repeat (ctl_d) @(posedge clk);
          #1;
          i2c_ack = attempt <= int'(cur.nacks);
          i2c_end = 1;
          repeat (int'(cur.hold)) @(posedge clk);
          #1;
          i2c_end = 0;
          i2c_ack = 0;
        end
        ctl_busy = 0;
      end
      c_prev = i2c_go;
    end
  end
  // monitor and reference model
  initial forever begin
    logic [NR-1:0] rsp;
    int g, exp_g;
    @(negedge clk);
    since_acc++;
    end_low = i2c_end ? 0 : end_low + 1;
    if (reset) begin
      in_flight = 0;
      go_prev = 0;
      model_last = NR - 1;
    end else begin
      rsp = req_done | req_err;
      if (rsp != '0) begin
        chk("resp_onehot", $countones(rsp) == 1 && (req_done & req_err) == '0, 1);
        chk("resp_expected", in_flight, 1);
        chk("resp_idx", rsp, 64'(1) << cur_idx);
        chk("resp_is_err", |req_err, exp_err);
        chk("resp_attempts", go_edges, exp_go);
        if (!exp_tmo) chk("resp_after_end_low", end_low >= 3, 1);
        if (|req_done) n_done++;
        else n_err++;
        in_flight = 0;
      end
      chk("busy", busy, in_flight);
      if (i2c_go && !go_prev) begin
        n_go++;
        go_edges++;
        go_len = 1;
        go_data_seen = i2c_data;
        chk("go_in_flight", in_flight, 1);
        chk("go_after_end_clear", end_low >= 4, 1);
        if (go_edges == 1) chk("accept_to_go", since_acc, 2);
      end else if (i2c_go) go_len++;
      if (!i2c_go && go_prev) chk("go_high_len", go_len, cur.hang ? TMO : ctl_d + 3);
      if (i2c_go) chk("go_data", i2c_data, cur.data);
      go_prev = i2c_go;
      if (req_ready != '0) begin
        chk("ready_onehot", $countones(req_ready), 1);
        chk("ready_not_in_flight", in_flight, 0);
        exp_g = -1;
        for (int k = 1; k <= NR; k++)
          if (exp_g < 0 && req_valid[(model_last + k) % NR]) exp_g = (model_last + k) % NR;
        g = 0;
        for (int i = NR - 1; i >= 0; i--) if (req_ready[i]) g = i;
        chk("rr_grant", g, exp_g);
        model_last = g;
        cur = ring[g][head[g]];
        popq[g] = 1;
        cur_idx = g;
        in_flight = 1;
        go_edges = 0;
        since_acc = 0;
        attempt = 0;
        grant_log.push_back(g);
        exp_tmo = cur.hang || int'(cur.hold) > TMO;
        if (exp_tmo) begin
          exp_err = 1;
          exp_go = 1;
        end else begin
`ifdef I2C_ARB_RETRY_EN
          exp_err = int'(cur.nacks) > MR;
          exp_go = exp_err ? MR + 1 : int'(cur.nacks) + 1;
`else
          exp_err = cur.nacks != 0;
          exp_go = 1;
`endif
        end
      end
    end
  end
  initial begin
    int g0, d0, e0, n0, n;
    tbl[0] = '{3'b011, 0, 2, 0, 1, 2, 0};
    tbl[1] = '{3'b111, 0, 3, 0, 1, 3, 0};
    tbl[2] = '{3'b100, 0, 1, 0, 2, 1, 0};
    tbl[3] = '{3'b101, 0, 2, 1, 0, 0, 2};
    tbl[4] = '{3'b110, 0, 50, 0, 1, 2, 0};
    tbl[5] = '{3'b001, 0, 130, 0, 0, 0, 1};
    tbl[6] = '{3'b011, 0, 2, 0, 1, 2, 0};
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
      popq[i] = 0;
    end
    reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_go", i2c_go, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", req_done, 0);
    chk("rst_err", req_err, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    repeat (2) @(negedge clk);
    g0 = grant_log.size(); d0 = n_done; e0 = n_err;
    enq(0, 24'h340E4D, 0, 3, 0);
    wait_idle();
    chk("single_grant", grant_log[g0], 0);
    chk("single_go_data", go_data_seen, 24'h340E4D);
    chk("single_done", n_done - d0, 1);
    chk("single_err", n_err - e0, 0);
    chk("single_busy_low", busy, 0);
    for (int e = 0; e < 7; e++) begin
      @(negedge clk);
      g0 = grant_log.size(); d0 = n_done; e0 = n_err;
      for (int i = 0; i < NR; i++)
        if (tbl[e].mask[i]) enq(i, 24'($urandom), tbl[e].nacks, tbl[e].hold, tbl[e].hang);
      wait_idle();
      chk($sformatf("vec%0d_first_grant", e), grant_log[g0], tbl[e].exp_first);
      chk($sformatf("vec%0d_done", e), n_done - d0, tbl[e].exp_done);
      chk($sformatf("vec%0d_err", e), n_err - e0, tbl[e].exp_err);
    end
    d0 = n_done; e0 = n_err; n0 = n_go;
    enq(0, 24'h5A0102, 10, 2, 0);
    wait_idle();
    chk("nack_go_edges", n_go - n0, NACK_GO);
    chk("nack_err", n_err - e0, 1);
    chk("nack_done", n_done - d0, 0);
    d0 = n_done; e0 = n_err; n0 = n_go;
    enq(1, 24'h5A0304, 2, 3, 0);
    wait_idle();
    chk("nack2_go_edges", n_go - n0, N2_GO);
    chk("nack2_err", n_err - e0, N2_ERR);
    chk("nack2_done", n_done - d0, 1 - N2_ERR);
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, NR - 1);
      if ((tail[r] - head[r] + 16) % 16 < 12)
        enq(r, 24'($urandom), ($urandom_range(0, 9) < 5) ? 0 : $urandom_range(1, 5),
            ($urandom_range(0, 4) == 0) ? $urandom_range(30, 60) : $urandom_range(1, 4),
            $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_idle();
    @(negedge clk);
    d0 = n_done; e0 = n_err;
    enq(0, 24'hABCDEF, 0, 2, 1);
    n = 0;
    while (!i2c_go && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_go_started", i2c_go, 1);
    repeat (20) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("rst_mid_go_async", i2c_go, 0);
    chk("rst_mid_busy_async", busy, 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_data", i2c_data, 0);
    chk("rst_mid_done", req_done, 0);
    chk("rst_mid_err", req_err, 0);
    reset = 0;
    g0 = grant_log.size();
    for (int i = 0; i < NR; i++) enq(i, 24'h100 + 24'(i), 0, 2, 0);
    wait_idle();
    chk("rst_mid_first_grant", grant_log[g0], 0);
    chk("rst_mid_done_after", n_done - d0, 3);
    chk("rst_mid_no_err", n_err - e0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_cmd_arbiter.md
# i2c_cmd_arbiter

Shares the single I2C_Controller write engine between several command requesters: the power-on codec/decoder configuration sequencer and runtime writers such as volume or mute control. It runs on CLOCK_50 and accepts 24-bit `{slave_addr, sub_addr, data}` commands over per-requester valid/ready ports. It grants one requester at a time, round-robin, drives GO/I2C_DATA into the controller, and turns the END/ACK result into a per-requester done or error pulse. It includes a timeout and optional NACK retry.

## Interface
- NUM_REQ, 2, number of requesters (1..8)
- MAX_RETRY, 3, extra attempts after a NACK (used only with retry compiled in)
- TIMEOUT_CYC, 2000000, CLOCK_50 cycles allowed per wait phase before abort (40 ms)

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a command pending
- req_data  in  24*NUM_REQ  command of requester i in bits [24i+23:24i]
- req_ready  out  NUM_REQ  one-hot accept strobe; transfer when valid&ready
- req_done  out  NUM_REQ  one-cycle pulse: command of requester i acknowledged
- req_err  out  NUM_REQ  one-cycle pulse: command of requester i failed (NACK exhausted or timeout)
- busy  out  1  high from accept until the response pulse
- i2c_go  out  1  GO level to I2C_Controller
- i2c_data  out  24  I2C_DATA to I2C_Controller, stable while i2c_go high
- i2c_end  in  1  END from I2C_Controller (slow clock domain)
- i2c_ack  in  1  ACK from I2C_Controller; 1 = NACK seen, 0 = all bytes acknowledged

## Operation
- i2c_end and i2c_ack each pass through a 2-flop synchronizer (end_s, ack_s).
- IDLE: if any req_valid is set, grant the first set bit searching upward from last_grant+1, wrapping at NUM_REQ. Pulse req_ready[g] for one cycle. Latch req_data[g] into i2c_data, set last_grant=g, clear the retry count, assert busy, go to LAUNCH.
- LAUNCH: set i2c_go=1, clear the timer, go to WAIT_END.
- WAIT_END: when end_s=1, capture ack_s, set i2c_go=0, and go to WAIT_CLR. If the timer reaches TIMEOUT_CYC-1 first, set i2c_go=0, mark a timeout, and go to WAIT_CLR.
- WAIT_CLR: wait for end_s=0, which ensures a stale END cannot complete the next command. The timer restarts on entry. A timeout here also marks a timeout. Then go to RESP.
- RESP, outcome order:
  - Timeout → req_err[g].
  - ack=0 → req_done[g].
  - ack=1 → retry or req_err[g] (see Configuration).
  - Pulses last one cycle. busy clears on the same cycle, and the block returns to IDLE.
- Retry path: increment the retry count and go to LAUNCH; i2c_data is unchanged and busy stays high.
- Only one command is in flight. Requesters not granted wait with valid held; req_ready is never high for two requesters at once.
- The timer is sized $clog2(TIMEOUT_CYC) bits. The retry count is $clog2(MAX_RETRY+1) bits, minimum 1.

## Timing
- Reset values: i2c_go=0, i2c_data=0, req_ready=0, req_done=0, req_err=0, busy=0, state IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first).
- Accept to i2c_go rise: 2 cycles (ready cycle, LAUNCH cycle, high from the next edge).
- END edge to i2c_go fall: 3 cycles (2 synchronizer flops + WAIT_END).
- Response pulse comes ≥3 cycles after END falls. The next accept can occur on the cycle after RESP.
- If a requester drops req_valid without a handshake, nothing is granted. Once req_ready has pulsed, the command is committed.
- If reset asserts mid-transfer, i2c_go drops immediately and every output returns to its reset value. No done/err pulse is issued for the aborted command.
- A simultaneous timeout expiry and end_s=1 in WAIT_END is treated as END (not a timeout).

## Configuration
- I2C_ARB_RETRY_EN defined: on NACK with retry count < MAX_RETRY, relaunch the same command. Once the count equals MAX_RETRY, report req_err. A command therefore gets at most MAX_RETRY+1 attempts.
- Not defined: the first NACK produces req_err immediately, and the retry counter logic is absent. Timeout behaviour is identical in both builds.

## Test plan
- Single command: req_valid[0]=1, data 24'h34_0E4D, controller model ends with ack=0 → one req_ready[0] pulse; i2c_data=24'h340E4D while i2c_go=1; i2c_go high 2 cycles after accept; one req_done[0]; busy then low.
- Round-robin: both valid, fixed data → grants alternate 0,1,0,1 over 4 commands; never two ready bits high in one cycle.
- NACK with I2C_ARB_RETRY_EN, MAX_RETRY=3, model always NACKs → exactly 4 i2c_go rising edges, then one req_err; no req_done. Without the macro → 1 GO edge, then req_err.
- Timeout: TIMEOUT_CYC=100, i2c_end held 0 → i2c_go falls after 100 cycles in WAIT_END; req_err pulses; next queued request is then granted.
- Stale END: i2c_end held high 50 cycles after completion → no response pulse until end_s=0; next i2c_go rises only after that.
- Reset mid-WAIT_END → i2c_go=0 and busy=0 asynchronously; no done/err; after release, requester 0 is granted first.
